// File: rtl/spm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spm_pkg
// Brief    : Shared constants, state encoding and helpers for the spm host.
// Revision : 1.0
// ============================================================================
package spm_pkg;

  localparam int SPM_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } spm_host_state_t;

  // Width of a counter able to index every bit of a 2*size product.
  function automatic int cnt_width(input int size);
    return $clog2(2 * size);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spm_host_if.sv
`default_nettype none
// ============================================================================
// Module   : spm_host_if
// Brief    : Operand/result handshake bundle between bus logic and spm_host.
// Revision : 1.0
// ============================================================================
interface spm_host_if #(
  parameter int SIZE = spm_pkg::SPM_SIZE
);

  logic                start_valid;
  logic                start_ready;
  logic [SIZE-1:0]     a;
  logic [SIZE-1:0]     b;
  logic                res_valid;
  logic                res_ready;
  logic [2*SIZE-1:0]   result;

  modport master (
    output start_valid, a, b, res_ready,
    input  start_ready, res_valid, result
  );

  modport slave (
    input  start_valid, a, b, res_ready,
    output start_ready, res_valid, result
  );

endinterface
`default_nettype wire

// File: rtl/spm_host.sv
`default_nettype none
// ============================================================================
// Module   : spm_host
// Brief    : Drives the serial-parallel multiplier spm: parallel operands in,
//            serial multiplier out, serial product deserialized to a result.
// Revision : 1.0
// ============================================================================
module spm_host
  import spm_pkg::*;
#(
  parameter int SIZE = SPM_SIZE
) (
  input  wire logic              clk,
  input  wire logic              rst,
  spm_host_if.slave              bus,
  output logic [SIZE-1:0]        spm_x,
  output logic                   spm_y,
  output logic                   spm_rst,
  input  wire logic              spm_p
);

  localparam int              W        = 2 * SIZE;
  localparam int              CW       = cnt_width(SIZE);
  localparam logic [CW-1:0]   CNT_LAST = CW'(W - 1);

  spm_host_state_t  state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SIZE-1:0]  mplr_q, mplr_d;
  logic [SIZE-1:0]  spm_x_q, spm_x_d;
  logic [W-1:0]     res_q, res_d;
  logic             spm_y_q, spm_y_d;
  logic             spm_rst_q, spm_rst_d;
  logic             start_ready_q, start_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mplr_q        <= '0;
      spm_x_q       <= '0;
      res_q         <= '0;
      spm_y_q       <= 1'b0;
      spm_rst_q     <= 1'b1;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mplr_q        <= mplr_d;
      spm_x_q       <= spm_x_d;
      res_q         <= res_d;
      spm_y_q       <= spm_y_d;
      spm_rst_q     <= spm_rst_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
    end
  end

  always_comb begin
    accept  = (state_q == IDLE) && bus.start_valid;
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is registered, so each one is computed from the next state.
  always_comb begin
    cnt_d         = cnt_q;
    mplr_d        = mplr_q;
    spm_x_d       = spm_x_q;
    res_d         = res_q;
    spm_y_d       = 1'b0;
    spm_rst_d     = !((state_d == SHIFT) || (state_d == DRAIN));
    start_ready_d = (state_d == IDLE);
    res_valid_d   = (state_d == DONE);

    case (state_q)
      IDLE: begin
        if (accept) begin
          spm_x_d = bus.a;
          spm_y_d = bus.b[0];
          mplr_d  = {bus.b[SIZE-1], bus.b[SIZE-1:1]};
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        // Arithmetic shift replicates the sign bit once b is exhausted.
        if (state_d == SHIFT) begin
          spm_y_d = mplr_q[0];
          mplr_d  = {mplr_q[SIZE-1], mplr_q[SIZE-1:1]};
        end
        if (cnt_q != '0) res_d = {spm_p, res_q[W-1:1]};
      end
      DRAIN: begin
        res_d = {spm_p, res_q[W-1:1]};
      end
      default: ;
    endcase
  end

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.result      = res_q;
  assign spm_x           = spm_x_q;
  assign spm_y           = spm_y_q;
  assign spm_rst         = spm_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_spm_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_spm_host
// Brief    : Scoreboard bench for spm_host with a behavioural spm alongside.
// Revision : 1.0
// ============================================================================
module tb_spm_host;
  import spm_pkg::*;

  localparam int SIZE = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SIZE-1:0]  spm_x;
  logic             spm_y;
  logic             spm_rst;
  logic             spm_p;

  spm_host_if #(.SIZE(SIZE)) bus ();

  spm_host #(.SIZE(SIZE)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .spm_x   (spm_x),
    .spm_y   (spm_y),
    .spm_rst (spm_rst),
    .spm_p   (spm_p)
  );

  always #5 clk = ~clk;

  // Behavioural spm: product bit k appears one edge after multiplier bit k.
  logic [6:0]   m_cnt;
  logic [63:0]  m_yacc;
  logic [63:0]  m_yn;
  logic [63:0]  m_prod;
  logic [63:0]  m_xs;

  assign m_xs   = {{32{spm_x[31]}}, spm_x};
  assign m_yn   = m_yacc | (64'(spm_y) << m_cnt[5:0]);
  assign m_prod = m_xs * m_yn;

  always @(posedge clk) begin
    if (spm_rst) begin
      m_cnt  <= '0;
      m_yacc <= '0;
      spm_p  <= 1'b0;
    end else if (m_cnt < 7'd64) begin
      m_yacc <= m_yn;
      spm_p  <= m_prod[m_cnt[5:0]];
      m_cnt  <= m_cnt + 7'd1;
    end
  end

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc      = 0;
  int           acc_cnt  = 0;
  int           pop_cnt  = 0;
  int           last_acc = 0;
  int           prev_acc = -1;
  bit           spacing_on = 0;
  bit           rv_prev  = 0;
  logic [63:0]  sb[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb;
    xa = {{32{a[31]}}, a};
    xb = {{32{b[31]}}, b};
    return xa * xb;
  endfunction

  // Called at a negedge with inputs settled; observes the coming edge.
  task automatic step();
    if (!rst) begin
      if (bus.res_valid && !rv_prev) check_eq("latency", 64'(cyc - last_acc), 64'd65);
      rv_prev = bus.res_valid;
      if (bus.start_valid && bus.start_ready) begin
        sb.push_back(smul(bus.a, bus.b));
        if (spacing_on && prev_acc >= 0) check_eq("spacing", 64'(cyc + 1 - prev_acc), 64'd67);
        prev_acc = cyc + 1;
        last_acc = cyc + 1;
        acc_cnt++;
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) check_eq("sb_empty", 64'(sb.size()), 64'd1);
        else check_eq("result", bus.result, sb.pop_front());
        pop_cnt++;
      end
    end else begin
      rv_prev = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    int a0 = acc_cnt;
    int p0 = pop_cnt;
    bus.a = a;
    bus.b = b;
    bus.start_valid = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 10 && acc_cnt == a0; i++) step();
    bus.start_valid = 1'b0;
    check_eq("accepted", 64'(acc_cnt - a0), 64'd1);
    check_eq("spm_x", 64'(spm_x), 64'(a));
    for (int i = 0; i < 200 && pop_cnt == p0; i++) step();
    check_eq("popped", 64'(pop_cnt - p0), 64'd1);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_start_ready", 64'(bus.start_ready), 64'd1);
    check_eq("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check_eq("rst_result", bus.result, 64'd0);
    check_eq("rst_spm_x", 64'(spm_x), 64'd0);
    check_eq("rst_spm_y", 64'(spm_y), 64'd0);
    check_eq("rst_spm_rst", 64'(spm_rst), 64'd1);
  endtask

  initial begin
    int a0;
    int p0;
    int seen;
    bus.start_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    step();
    check_reset_outputs();
    step();
    rst = 1'b0;
    step();

    do_op(32'd3, 32'd5);
    do_op(32'hFFFF_FFFD, 32'd5);
    do_op(32'h8000_0000, 32'h8000_0000);
    do_op(32'h7FFF_FFFF, 32'h8000_0000);

    // Result held while the consumer stalls; starts are refused meanwhile.
    a0 = acc_cnt;
    p0 = pop_cnt;
    bus.a = 32'h0001_2345;
    bus.b = 32'hFFFF_FFB3;
    bus.start_valid = 1'b1;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 10 && acc_cnt == a0; i++) step();
    bus.start_valid = 1'b0;
    for (int i = 0; i < 200 && !bus.res_valid; i++) step();
    for (int i = 0; i < 20; i++) begin
      check_eq("hold_valid", 64'(bus.res_valid), 64'd1);
      check_eq("hold_result", bus.result, smul(32'h0001_2345, 32'hFFFF_FFB3));
      check_eq("hold_ready", 64'(bus.start_ready), 64'd0);
      if (i == 5) begin
        bus.a = 32'd9;
        bus.b = 32'd9;
        bus.start_valid = 1'b1;
      end else begin
        bus.start_valid = 1'b0;
      end
      step();
    end
    bus.start_valid = 1'b0;
    check_eq("hold_no_accept", 64'(acc_cnt - a0), 64'd1);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 10 && pop_cnt == p0; i++) step();
    check_eq("hold_popped", 64'(pop_cnt - p0), 64'd1);
    check_eq("hold_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of SHIFT.
    a0 = acc_cnt;
    bus.a = 32'h1234_5678;
    bus.b = 32'h0BAD_F00D;
    bus.start_valid = 1'b1;
    for (int i = 0; i < 10 && acc_cnt == a0; i++) step();
    bus.start_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    sb.delete();
    step();
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.res_valid) seen++;
      step();
    end
    check_eq("no_res_after_rst", 64'(seen), 64'd0);
    do_op(32'd7, 32'hFFFF_FFFE);
    check_eq("post_rst_value", smul(32'd7, 32'hFFFF_FFFE), 64'hFFFF_FFFF_FFFF_FFF2);

    // Back-to-back operations with random operands.
    p0 = pop_cnt;
    spacing_on = 1'b1;
    prev_acc = -1;
    bus.res_ready = 1'b1;
    bus.start_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a0 = acc_cnt;
      bus.a = $urandom;
      bus.b = $urandom;
      for (int i = 0; i < 100 && acc_cnt == a0; i++) step();
      check_eq("b2b_accept", 64'(acc_cnt - a0), 64'd1);
    end
    bus.start_valid = 1'b0;
    for (int i = 0; i < 200 && pop_cnt < p0 + 8; i++) step();
    spacing_on = 1'b0;
    check_eq("b2b_pops", 64'(pop_cnt - p0), 64'd8);
    check_eq("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
